// File: rtl/sipo_shift_receiver_pkg.sv
// Shared types and defaults for the serial-in/parallel-out receiver.
package sipo_pkg;

  typedef enum logic {IDLE, RECV} sipo_state_t;

  localparam int SIPO_DEF_WIDTH = 4;

endpackage

// File: rtl/sipo_shift_receiver_bit_counter.sv
// Bit-position counter for the receiver. It counts qualified bits within a frame.
// A frame start loads the count with 1, because the start bit is itself bit 0.
// The last flag marks the position where the incoming bit completes the word.
module sipo_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic areset,
  input  logic clr,
  input  logic load1,
  input  logic inc,
  output logic last
);

  logic [CNTW-1:0] cnt;

  // Count position: clear wins over load, and load wins over increment.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CNTW'(1);
    end else if (inc) begin
      cnt <= cnt + CNTW'(1);
    end
  end

  assign last = (cnt == CNTW'(WIDTH - 1));

endmodule

// File: rtl/sipo_shift_receiver.sv
// Serial-in/parallel-out receiver, LSB first, with framing by frame_start.
// Completed words go into a one-word holding register with a valid/ready interface.
// A word that completes while the holding register is still full is dropped.
// That drop sets the sticky overrun flag.
module sipo_shift_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             sin,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNTW = $clog2(WIDTH);

  sipo_state_t      state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic             last;
  logic             start_bit;
  logic             data_bit;
  logic             word_done;
  logic             can_load;

  // New bits enter at the top, so after WIDTH shifts the first bit sits in bit 0.
  assign shifted   = {sin, sr[WIDTH-1:1]};
  assign start_bit = bit_en && frame_start;
  assign data_bit  = bit_en && !frame_start && (state == RECV);
  assign word_done = data_bit && last;
  // The holding register can accept a word when it is empty or draining this cycle.
  assign can_load  = !out_valid || out_ready;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_bit_counter (
    .clk    (clk),
    .areset (areset),
    .clr    (clr || word_done),
    .load1  (start_bit),
    .inc    (data_bit && !last),
    .last   (last)
  );

  // Frame FSM, shift register, holding register and status flags.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      sr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      sr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (start_bit) begin
        // A start bit during RECV abandons the partial word and restarts the frame.
        sr    <= shifted;
        state <= RECV;
        busy  <= 1'b1;
        if (state == RECV) begin
          frame_err <= 1'b1;
        end
      end else if (data_bit) begin
        sr <= shifted;
        if (last) begin
          state <= IDLE;
          busy  <= 1'b0;
          if (can_load) begin
            out_data  <= shifted;
            out_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo_shift_receiver.sv
// Directed bench for sipo_shift_receiver at WIDTH=4.
module tb_sipo_shift_receiver;

  logic       clk = 1'b0;
  logic       areset;
  logic       clr;
  logic       bit_en;
  logic       sin;
  logic       frame_start;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  sipo_shift_receiver #(.WIDTH(4)) dut (
    .clk         (clk),
    .areset      (areset),
    .clr         (clr),
    .bit_en      (bit_en),
    .sin         (sin),
    .frame_start (frame_start),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // One qualified bit: present it for exactly one rising edge, return on the next falling edge
  task automatic send_bit(input logic fs, input logic b);
    @(negedge clk);
    bit_en = 1'b1; frame_start = fs; sin = b;
    @(negedge clk);
    bit_en = 1'b0; frame_start = 1'b0; sin = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    areset = 1'b1; clr = 1'b0; bit_en = 1'b0; sin = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    gap(2);
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_data got %h want %h", out_data, 4'h0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b ferr=%b ovr=%b want 000", busy, frame_err, overrun); end
    @(negedge clk); areset = 1'b0;
    gap(1);
  endtask

  task automatic test_first_word;
    send_bit(1'b1, 1'b1); gap(2);
    send_bit(1'b0, 1'b0); gap(1);
    send_bit(1'b0, 1'b1); gap(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %b want 0", out_valid); end
    send_bit(1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 4'hD) begin errors++; $display("FAIL t1_data got %h want %h", out_data, 4'hD); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_end got %b want 0", busy); end
  endtask

  task automatic test_overrun_clr;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    checks++; if (out_data !== 4'hD) begin errors++; $display("FAIL t2_data_held got %h want %h", out_data, 4'hD); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL t2_overrun got %b want 1", overrun); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t2_valid got %b want 1", out_valid); end
    gap(2);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL t2_overrun_sticky got %b want 1", overrun); end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_clr_valid got %b want 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL t2_clr_overrun got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1);
    checks++; if (out_data !== 4'hD || out_valid !== 1'b1) begin
      errors++; $display("FAIL t3_hold got %h/%b want d/1", out_data, out_valid); end
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    out_ready = 1'b0;
    checks++; if (out_data !== 4'h6) begin errors++; $display("FAIL t3_data got %h want %h", out_data, 4'h6); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t3_valid got %b want 1", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL t3_overrun got %b want 0", overrun); end
    gap(2);
    checks++; if (out_data !== 4'h6) begin errors++; $display("FAIL t3_stable got %h want %h", out_data, 4'h6); end
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t3_drain got %b want 0", out_valid); end
  endtask

  task automatic test_frame_err;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL t4_no_err got %b want 0", frame_err); end
    send_bit(1'b1, 1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL t4_err got %b want 1", frame_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy got %b want 1", busy); end
    send_bit(1'b0, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL t4_err_pulse got %b want 0", frame_err); end
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1);
    checks++; if (out_data !== 4'h8 || out_valid !== 1'b1) begin
      errors++; $display("FAIL t4_data got %h/%b want 8/1", out_data, out_valid); end
  endtask

  task automatic test_async_reset;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1);
    #2 areset = 1'b1;
    #1;
    checks++; if (out_data !== 4'h0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL t5_rst_out got %h/%b want 0/0", out_data, out_valid); end
    checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL t5_rst_flags got busy=%b ferr=%b ovr=%b want 000", busy, frame_err, overrun); end
    @(negedge clk); areset = 1'b0;
    send_bit(1'b0, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_no_residue got %b want 0", busy); end
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1);
    checks++; if (out_data !== 4'hA || out_valid !== 1'b1) begin
      errors++; $display("FAIL t5_data got %h/%b want a/1", out_data, out_valid); end
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_idle_discard;
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b0, i[0]);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL t6_idle_%0d got busy=%b valid=%b want 0/0", i, busy, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_overrun_clr();
    test_back_to_back();
    test_frame_err();
    test_async_reset();
    test_idle_discard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
